// File: rtl/sha256_compress_core.sv
// sha256_compress_core: iterative SHA-256 compression, one round per accepted W word.
// Rev 1.0
`default_nettype none

module sha256_compress_core #(
   parameter int ROUNDS = 64
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic [255:0] H_in,
   input  logic [31:0]  W_in,
   input  logic         W_valid,
   output logic         W_ready,
   output logic [255:0] DIGEST_out,
   output logic         BUSY,
   output logic         DONE
);

   localparam logic [6:0] C_LAST_T = 7'(ROUNDS - 1);

   localparam logic [0:63][31:0] C_K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   state_t       state_q;
   logic [6:0]   t_q;
   logic [31:0]  a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
   logic [255:0] hreg_q;
   logic [255:0] digest_q;
   logic         w_ready_q;
   logic         busy_q;
   logic         done_q;

   logic [31:0]  ep0_d, ep1_d, ch_d, maj_d, t1_d, t2_d;
   logic         accept_d;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   always_comb begin
      ep0_d    = rotr(a_q, 2) ^ rotr(a_q, 13) ^ rotr(a_q, 22);
      ep1_d    = rotr(e_q, 6) ^ rotr(e_q, 11) ^ rotr(e_q, 25);
      ch_d     = (e_q & f_q) ^ (~e_q & g_q);
      maj_d    = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
      t1_d     = h_q + ep1_d + ch_d + C_K[t_q[5:0]] + W_in;
      t2_d     = ep0_d + maj_d;
      accept_d = W_valid & w_ready_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         t_q       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
         d_q       <= '0;
         e_q       <= '0;
         f_q       <= '0;
         g_q       <= '0;
         h_q       <= '0;
         hreg_q    <= '0;
         digest_q  <= '0;
         w_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (START) begin
                  hreg_q    <= H_in;
                  a_q       <= H_in[255:224];
                  b_q       <= H_in[223:192];
                  c_q       <= H_in[191:160];
                  d_q       <= H_in[159:128];
                  e_q       <= H_in[127:96];
                  f_q       <= H_in[95:64];
                  g_q       <= H_in[63:32];
                  h_q       <= H_in[31:0];
                  t_q       <= '0;
                  busy_q    <= 1'b1;
                  w_ready_q <= 1'b1;
                  state_q   <= S_ROUND;
               end
            end
            S_ROUND: begin
               // No accepted word means a stall: every register holds.
               if (accept_d) begin
                  h_q <= g_q;
                  g_q <= f_q;
                  f_q <= e_q;
                  e_q <= d_q + t1_d;
                  d_q <= c_q;
                  c_q <= b_q;
                  b_q <= a_q;
                  a_q <= t1_d + t2_d;
                  t_q <= t_q + 7'd1;
                  if (t_q == C_LAST_T) begin
                     w_ready_q <= 1'b0;
                     state_q   <= S_FINAL;
                  end
               end
            end
            S_FINAL: begin
               digest_q <= {hreg_q[255:224] + a_q, hreg_q[223:192] + b_q,
                            hreg_q[191:160] + c_q, hreg_q[159:128] + d_q,
                            hreg_q[127:96]  + e_q, hreg_q[95:64]   + f_q,
                            hreg_q[63:32]   + g_q, hreg_q[31:0]    + h_q};
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: begin
               w_ready_q <= 1'b0;
               busy_q    <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign W_ready    = w_ready_q;
   assign DIGEST_out = digest_q;
   assign BUSY       = busy_q;
   assign DONE       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sha256_compress_core.sv
// tb_sha256_compress_core: randomized and known-answer checks against a plain SHA-256 model.
// Rev 1.0
`default_nettype none

module tb_sha256_compress_core;

   logic         CLK = 1'b0;
   logic         RST;
   logic         START;
   logic [255:0] H_in;
   logic [31:0]  W_in;
   logic         W_valid;
   logic         W_ready;
   logic [255:0] DIGEST_out;
   logic         BUSY;
   logic         DONE;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [255:0] C_IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] C_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] C_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] C_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   sha256_compress_core #(.ROUNDS(64)) u_dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
      .H_in       (H_in),
      .W_in       (W_in),
      .W_valid    (W_valid),
      .W_ready    (W_ready),
      .DIGEST_out (DIGEST_out),
      .BUSY       (BUSY),
      .DONE       (DONE)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   task automatic expand(input logic [31:0] m [16], output logic [31:0] w [64]);
      logic [31:0] s0, s1;
      for (int i = 0; i < 16; i++) w[i] = m[i];
      for (int i = 16; i < 64; i++) begin
         s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
   endtask

   function automatic logic [255:0] compress(input logic [255:0] h, input logic [31:0] w [64]);
      logic [31:0]  v [8];
      logic [31:0]  t1, t2;
      logic [255:0] res;
      for (int i = 0; i < 8; i++) v[i] = h[255-32*i -: 32];
      for (int r = 0; r < 64; r++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[r] + w[r];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = h[255-32*i -: 32] + v[i];
      return res;
   endfunction

   // Drives one block starting in the current cycle (cycle 0) and returns in the DONE cycle.
   task automatic run_block(input logic [255:0] h, input logic [31:0] w [64], input int stalls,
                            input bit restart, output logic [255:0] dig, output int done_cyc,
                            output int viol);
      int idx, cyc, sl;
      logic [255:0] prev;
      idx = 0; cyc = 0; sl = stalls; viol = 0; done_cyc = -1; dig = '0;
      prev = DIGEST_out;
      START = 1'b1; H_in = h; W_valid = 1'b0; W_in = $urandom;
      while (cyc < 300 && done_cyc < 0) begin
         @(posedge CLK); #1; cyc++;
         START = 1'b0;
         if (restart && (idx == 5 || idx == 40)) begin
            START = 1'b1;
            H_in  = ~h;
         end
         if (W_ready !== (idx < 64)) viol++;
         if (BUSY !== !DONE) viol++;
         if (!DONE && DIGEST_out !== prev) viol++;
         if (DONE) begin
            done_cyc = cyc;
            dig      = DIGEST_out;
            W_valid  = 1'b0;
            START    = 1'b0;
         end else if (idx < 64) begin
            if (sl > 0 && ($urandom_range(0, 3) == 0 || idx == 63)) begin
               W_valid = 1'b0; W_in = $urandom; sl--;
            end else begin
               W_valid = 1'b1; W_in = w[idx]; idx++;
            end
         end else begin
            W_valid = 1'($urandom_range(0, 1));
            W_in    = $urandom;
         end
      end
      if (done_cyc < 0) W_valid = 1'b0;
   endtask

   task automatic abc_words(output logic [31:0] w [64]);
      logic [31:0] m [16];
      for (int i = 0; i < 16; i++) m[i] = '0;
      m[0] = 32'h61626380; m[15] = 32'h00000018;
      expand(m, w);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      RST = 1'b1; START = 1'b0; W_valid = 1'b0; W_in = '0; H_in = '0;
      repeat (3) @(posedge CLK);
      #1;
      n_cmp++; if (DIGEST_out !== '0) begin n_bad++; $display("FAIL reset_digest got %h want 0", DIGEST_out); end
      n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", BUSY); end
      n_cmp++; if (DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", DONE); end
      n_cmp++; if (W_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wready got %b want 0", W_ready); end
      RST = 1'b0; W_valid = 1'b1;
      @(posedge CLK); #1;
      n_cmp++; if (W_ready !== 1'b0 || BUSY !== 1'b0) begin
         n_bad++; $display("FAIL idle_ignores_wvalid got wready=%b busy=%b want 0/0", W_ready, BUSY);
      end
      W_valid = 1'b0;
   endtask

   task automatic test_abc();
      logic [31:0] w [64]; logic [255:0] dig; int dc, viol;
      abc_words(w);
      run_block(C_IV, w, 0, 1'b0, dig, dc, viol);
      n_cmp++; if (dig !== C_ABC) begin n_bad++; $display("FAIL abc_digest got %h want %h", dig, C_ABC); end
      n_cmp++; if (dig !== compress(C_IV, w)) begin n_bad++; $display("FAIL abc_model got %h want %h", dig, compress(C_IV, w)); end
      n_cmp++; if (dc !== 66) begin n_bad++; $display("FAIL abc_done_cycle got %0d want 66", dc); end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL abc_handshake got %0d violations want 0", viol); end
      @(posedge CLK); #1;
      n_cmp++; if (DONE !== 1'b0 || DIGEST_out !== C_ABC) begin
         n_bad++; $display("FAIL abc_hold got done=%b dig=%h want 0/%h", DONE, DIGEST_out, C_ABC);
      end
   endtask

   task automatic test_empty();
      logic [31:0] m [16]; logic [31:0] w [64]; logic [255:0] dig; int dc, viol;
      for (int i = 0; i < 16; i++) m[i] = '0;
      m[0] = 32'h80000000;
      expand(m, w);
      run_block(C_IV, w, 0, 1'b0, dig, dc, viol);
      n_cmp++; if (dig !== C_EMPTY) begin n_bad++; $display("FAIL empty_digest got %h want %h", dig, C_EMPTY); end
      n_cmp++; if (dc !== 66 || viol !== 0) begin n_bad++; $display("FAIL empty_timing got cyc=%0d viol=%0d want 66/0", dc, viol); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] m [16]; logic [31:0] w1 [64]; logic [31:0] w2 [64];
      logic [255:0] d1, d2; int dc1, dc2, v1, v2;
      m = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      expand(m, w1);
      for (int i = 0; i < 16; i++) m[i] = '0;
      m[15] = 32'h000001c0;
      expand(m, w2);
      run_block(C_IV, w1, 0, 1'b0, d1, dc1, v1);
      run_block(d1, w2, 0, 1'b0, d2, dc2, v2);
      n_cmp++; if (d1 !== compress(C_IV, w1)) begin n_bad++; $display("FAIL two_block_first got %h want %h", d1, compress(C_IV, w1)); end
      n_cmp++; if (d2 !== C_TWO) begin n_bad++; $display("FAIL two_block_digest got %h want %h", d2, C_TWO); end
      n_cmp++; if (dc1 !== 66 || dc2 !== 66) begin n_bad++; $display("FAIL two_block_cycles got %0d/%0d want 66/66", dc1, dc2); end
      n_cmp++; if (v1 !== 0 || v2 !== 0) begin n_bad++; $display("FAIL two_block_handshake got %0d/%0d want 0/0", v1, v2); end
   endtask

   task automatic test_stalls();
      logic [31:0] w [64]; logic [255:0] dig; int dc, viol;
      abc_words(w);
      run_block(C_IV, w, 20, 1'b0, dig, dc, viol);
      n_cmp++; if (dig !== C_ABC) begin n_bad++; $display("FAIL stall_digest got %h want %h", dig, C_ABC); end
      n_cmp++; if (dc !== 86) begin n_bad++; $display("FAIL stall_done_cycle got %0d want 86", dc); end
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL stall_wready got %0d violations want 0", viol); end
   endtask

   task automatic test_start_ignored();
      logic [31:0] w [64]; logic [255:0] dig; int dc, viol;
      abc_words(w);
      run_block(C_IV, w, 0, 1'b1, dig, dc, viol);
      n_cmp++; if (dig !== C_ABC) begin n_bad++; $display("FAIL restart_digest got %h want %h", dig, C_ABC); end
      n_cmp++; if (dc !== 66 || viol !== 0) begin n_bad++; $display("FAIL restart_timing got cyc=%0d viol=%0d want 66/0", dc, viol); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w [64]; logic [255:0] dig; int dc, viol, dones;
      abc_words(w);
      START = 1'b1; H_in = C_IV; W_valid = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         @(posedge CLK); #1;
         START = 1'b0;
         if (c <= 31) begin W_valid = 1'b1; W_in = w[c-1]; end
         else W_valid = 1'b0;
      end
      n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL midrst_busy_before got %b want 1", BUSY); end
      #2 RST = 1'b1;
      #1;
      n_cmp++; if (DIGEST_out !== '0 || BUSY !== 1'b0 || DONE !== 1'b0 || W_ready !== 1'b0) begin
         n_bad++; $display("FAIL midrst_outputs got dig=%h busy=%b done=%b wready=%b want all 0", DIGEST_out, BUSY, DONE, W_ready);
      end
      @(posedge CLK); #1;
      RST = 1'b0;
      dones = 0;
      for (int c = 0; c < 80; c++) begin
         @(posedge CLK); #1;
         if (DONE === 1'b1 || BUSY === 1'b1) dones++;
      end
      n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d active cycles want 0", dones); end
      run_block(C_IV, w, 0, 1'b0, dig, dc, viol);
      n_cmp++; if (dig !== C_ABC || dc !== 66) begin n_bad++; $display("FAIL midrst_rerun got %h cyc=%0d want %h cyc=66", dig, dc, C_ABC); end
   endtask

   task automatic test_random();
      logic [31:0] w [64]; logic [255:0] h, dig, exp_d; int dc, viol, st;
      for (int i = 0; i < 8; i++) h[255-32*i -: 32] = $urandom;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 64; i++) w[i] = $urandom;
         st    = $urandom_range(0, 10);
         exp_d = compress(h, w);
         run_block(h, w, st, 1'b0, dig, dc, viol);
         n_cmp++; if (dig !== exp_d) begin n_bad++; $display("FAIL rand_digest[%0d] got %h want %h", b, dig, exp_d); end
         n_cmp++; if (dc !== 66 + st || viol !== 0) begin
            n_bad++; $display("FAIL rand_timing[%0d] got cyc=%0d viol=%0d want %0d/0", b, dc, viol, 66 + st);
         end
         h = dig;
      end
   endtask

   initial begin
      test_reset();
      test_abc();
      test_empty();
      test_back_to_back();
      test_stalls();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
